// File: rtl/bluemax_platform_cpu_debug_scan_master_pkg.sv
// -----------------------------------------------------------------------------
// bluemax_debug_pkg
// Shared definitions for the CPU debug scan master:
//   - scan_state_e : virtual-JTAG scan sequencer states
//   - IR_*         : virtual IR codes understood by the OCI debug slave
//   - DEFAULT_DR_WIDTH : default data-register scan length
// -----------------------------------------------------------------------------
package bluemax_debug_pkg;

    localparam int DEFAULT_DR_WIDTH = 38;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RSP  = 3'd6
    } scan_state_e;

endpackage

// File: rtl/bluemax_platform_cpu_debug_scan_master_if.sv
// -----------------------------------------------------------------------------
// bluemax_platform_cpu_debug_scan_master_if
// Command/response handshake between a command source and the scan master.
//   cmd_valid/cmd_ready : command handshake, carries cmd_ir and cmd_dr
//   rsp_valid/rsp_ready : response handshake, carries rsp_dr and rsp_ir_out
// Modports: master = command source, slave = scan master.
// -----------------------------------------------------------------------------
interface bluemax_platform_cpu_debug_scan_master_if #(
    parameter int DR_WIDTH = bluemax_debug_pkg::DEFAULT_DR_WIDTH,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [IR_WIDTH-1:0] rsp_ir_out;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );
endinterface

// File: rtl/bluemax_platform_cpu_debug_scan_master_tck_gen.sv
// -----------------------------------------------------------------------------
// bluemax_debug_tck_gen
// Divides clk into a TCK of 2*TCK_DIV clk per period, low half first.
//   clk_i, reset_i  : system clock, synchronous active-high reset
//   en_i            : run the divider; when low TCK parks low, phase restarts
//   tck_o           : registered TCK
//   tck_rise_o      : strobe on the clk edge where tck_o goes high
//   tck_fall_o      : strobe on the clk edge where tck_o goes low
//   period_done_o   : strobe on the clk edge that closes a full TCK period
// -----------------------------------------------------------------------------
module bluemax_debug_tck_gen #(
    parameter int TCK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic tck_o,
    output logic tck_rise_o,
    output logic tck_fall_o,
    output logic period_done_o
);
    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [DIV_W-1:0] cnt_q;
    logic             tck_q;
    logic             half_end;

    assign half_end      = en_i && (cnt_q == DIV_W'(TCK_DIV - 1));
    assign tck_rise_o    = half_end && !tck_q;
    assign tck_fall_o    = half_end && tck_q;
    // A period ends on the falling edge because each period starts low.
    assign period_done_o = half_end && tck_q;
    assign tck_o         = tck_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || !en_i) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else if (half_end) begin
            cnt_q <= '0;
            tck_q <= ~tck_q;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end
endmodule

// File: rtl/bluemax_platform_cpu_debug_scan_master.sv
// -----------------------------------------------------------------------------
// bluemax_platform_cpu_debug_scan_master
// On-chip virtual-JTAG scan initiator for the CPU debug slave. Each accepted
// command walks UIR -> CDR -> SDR (DR_WIDTH bits) -> UDR -> RTI and returns
// the word captured from vji_tdo together with vji_ir_out sampled in CDR.
//   clk, reset     : system clock, synchronous active-high reset
//   bus (slave)    : cmd_valid/ready/ir/dr in, rsp_valid/ready/dr/ir_out out
//   vji_tck/tdi    : generated TCK and serial data to the slave
//   vji_tdo        : serial data from the slave
//   vji_ir_in/out  : virtual IR to the slave / IR status from the slave
//   vji_uir..rti   : one-hot virtual-state indicators
// -----------------------------------------------------------------------------
module bluemax_platform_cpu_debug_scan_master
    import bluemax_debug_pkg::*;
#(
    parameter int DR_WIDTH   = DEFAULT_DR_WIDTH,
    parameter int IR_WIDTH   = 2,
    parameter int TCK_DIV    = 4,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    bluemax_platform_cpu_debug_scan_master_if.slave bus,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    scan_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DR_WIDTH-1:0] shift_q, cap_q, rsp_dr_q;
    logic [IR_WIDTH-1:0] ir_in_q, rsp_ir_q;
    logic                tdi_q, cmd_ready_q, rsp_valid_q;
    logic                uir_q, cdr_q, sdr_q, udr_q, rti_q;
    logic                tck_en, tck_rise, tck_fall, period_done;
    logic                accept;

    assign accept = bus.cmd_valid && cmd_ready_q;
    assign tck_en = state_q inside {ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI};

    bluemax_debug_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk_i         (clk),
        .reset_i       (reset),
        .en_i          (tck_en),
        .tck_o         (vji_tck),
        .tck_rise_o    (tck_rise),
        .tck_fall_o    (tck_fall),
        .period_done_o (period_done)
    );

    // Every scan state lasts whole TCK periods; cnt_q counts periods in SDR/RTI.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_UIR;
            ST_UIR:  if (period_done) state_d = ST_CDR;
            ST_CDR:  if (period_done) begin
                state_d = ST_SDR;
                cnt_d   = '0;
            end
            ST_SDR:  if (period_done) begin
                if (cnt_q == CNT_W'(DR_WIDTH - 1)) state_d = ST_UDR;
                else                               cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_UDR:  if (period_done) begin
                state_d = ST_RTI;
                cnt_d   = '0;
            end
            ST_RTI:  if (period_done) begin
                if (cnt_q == CNT_W'(RTI_CYCLES - 1)) state_d = ST_RSP;
                else                                 cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_RSP:  if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dr_q    <= '0;
            rsp_ir_q    <= '0;
            ir_in_q     <= '0;
            tdi_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            rti_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RSP);
            uir_q       <= (state_d == ST_UIR);
            cdr_q       <= (state_d == ST_CDR);
            sdr_q       <= (state_d == ST_SDR);
            udr_q       <= (state_d == ST_UDR);
            rti_q       <= (state_d == ST_RTI);
            if (accept) ir_in_q <= bus.cmd_ir;
            // Covers both SDR entry (bit 0) and every falling edge inside SDR.
            if (tck_fall && state_d == ST_SDR) tdi_q <= shift_q[0];
            if (tck_rise && state_q == ST_CDR) rsp_ir_q <= vji_ir_out;
            if (state_q == ST_RTI && state_d == ST_RSP) rsp_dr_q <= cap_q;
        end
    end

    // Shift/capture datapath: fully rewritten by every scan, so no reset.
    always_ff @(posedge clk) begin
        if (accept) shift_q <= bus.cmd_dr;
        else if (tck_fall && state_d == ST_SDR) shift_q <= shift_q >> 1;
        if (tck_rise && state_q == ST_SDR) cap_q <= {vji_tdo, cap_q[DR_WIDTH-1:1]};
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_dr     = rsp_dr_q;
    assign bus.rsp_ir_out = rsp_ir_q;
    assign vji_tdi        = tdi_q;
    assign vji_ir_in      = ir_in_q;
    assign vji_uir        = uir_q;
    assign vji_cdr        = cdr_q;
    assign vji_sdr        = sdr_q;
    assign vji_udr        = udr_q;
    assign vji_rti        = rti_q;
endmodule

// File: tb/tb_bluemax_platform_cpu_debug_scan_master.sv
// -----------------------------------------------------------------------------
// Directed bench for the CPU debug scan master: a default-parameter instance
// and a TCK_DIV=1/RTI_CYCLES=1 instance share stimulus, selected by sel.
// -----------------------------------------------------------------------------
module tb_bluemax_platform_cpu_debug_scan_master;
    import bluemax_debug_pkg::*;

    localparam int DRW = 38;
    localparam int IRW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, sel, cmd_valid, rsp_ready, tdo;
    logic [IRW-1:0]  cmd_ir, ir_out;
    logic [DRW-1:0]  cmd_dr;
    int checks   = 0;
    int failures = 0;

    bluemax_platform_cpu_debug_scan_master_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) if_d ();
    bluemax_platform_cpu_debug_scan_master_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) if_f ();

    assign if_d.cmd_valid = cmd_valid & ~sel;
    assign if_d.cmd_ir    = cmd_ir;
    assign if_d.cmd_dr    = cmd_dr;
    assign if_d.rsp_ready = rsp_ready & ~sel;
    assign if_f.cmd_valid = cmd_valid & sel;
    assign if_f.cmd_ir    = cmd_ir;
    assign if_f.cmd_dr    = cmd_dr;
    assign if_f.rsp_ready = rsp_ready & sel;

    logic           d_tck, d_tdi, d_uir, d_cdr, d_sdr, d_udr, d_rti;
    logic           f_tck, f_tdi, f_uir, f_cdr, f_sdr, f_udr, f_rti;
    logic [IRW-1:0] d_ir_in, f_ir_in;

    bluemax_platform_cpu_debug_scan_master dut (
        .clk(clk), .reset(reset), .bus(if_d),
        .vji_tck(d_tck), .vji_tdi(d_tdi), .vji_tdo(tdo),
        .vji_ir_in(d_ir_in), .vji_ir_out(ir_out),
        .vji_uir(d_uir), .vji_cdr(d_cdr), .vji_sdr(d_sdr), .vji_udr(d_udr), .vji_rti(d_rti)
    );

    bluemax_platform_cpu_debug_scan_master #(.TCK_DIV(1), .RTI_CYCLES(1)) dut_fast (
        .clk(clk), .reset(reset), .bus(if_f),
        .vji_tck(f_tck), .vji_tdi(f_tdi), .vji_tdo(tdo),
        .vji_ir_in(f_ir_in), .vji_ir_out(ir_out),
        .vji_uir(f_uir), .vji_cdr(f_cdr), .vji_sdr(f_sdr), .vji_udr(f_udr), .vji_rti(f_rti)
    );

    logic           o_cmd_ready, o_rsp_valid, o_tck, o_tdi, o_uir, o_cdr, o_sdr, o_udr, o_rti;
    logic [DRW-1:0] o_rsp_dr;
    logic [IRW-1:0] o_rsp_ir, o_ir_in;
    logic [50:0]    o_all;

    assign o_cmd_ready = sel ? if_f.cmd_ready  : if_d.cmd_ready;
    assign o_rsp_valid = sel ? if_f.rsp_valid  : if_d.rsp_valid;
    assign o_rsp_dr    = sel ? if_f.rsp_dr     : if_d.rsp_dr;
    assign o_rsp_ir    = sel ? if_f.rsp_ir_out : if_d.rsp_ir_out;
    assign o_tck       = sel ? f_tck   : d_tck;
    assign o_tdi       = sel ? f_tdi   : d_tdi;
    assign o_ir_in     = sel ? f_ir_in : d_ir_in;
    assign o_uir       = sel ? f_uir   : d_uir;
    assign o_cdr       = sel ? f_cdr   : d_cdr;
    assign o_sdr       = sel ? f_sdr   : d_sdr;
    assign o_udr       = sel ? f_udr   : d_udr;
    assign o_rti       = sel ? f_rti   : d_rti;
    assign o_all = {o_cmd_ready, o_rsp_valid, o_rsp_dr, o_rsp_ir, o_tck, o_tdi, o_ir_in,
                    o_uir, o_cdr, o_sdr, o_udr, o_rti};

    // Measurements filled in by run_scan
    int             lat, sdr_cyc, sdr_rises, toggles, udr_w, udr_rises, hold_bad;
    logic [DRW-1:0] rx, resp;
    logic [IRW-1:0] resp_ir, uir_ir;
    logic           post_ready, post_valid;

    // Issues one command, plays the slave (tdo word, tdi capture), measures.
    task automatic run_scan(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                            input logic [DRW-1:0] tdo_w, input int hold);
        int   bidx, w;
        logic p_tck, p_sdr;
        lat = 0; sdr_cyc = 0; sdr_rises = 0; toggles = 0; udr_w = 0; udr_rises = 0;
        hold_bad = 0; rx = '0; resp = '0; resp_ir = '0; uir_ir = '0;
        post_ready = 1'b0; post_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!o_cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!o_cmd_ready) begin
            checks++; failures++;
            $display("FAIL scan_start cmd_ready=%b required=1", o_cmd_ready);
            return;
        end
        cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1; rsp_ready = 1'b0;
        bidx = 0; tdo = tdo_w[0];
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        p_tck = 1'b0; p_sdr = 1'b0;
        while (lat < 3000) begin
            if (o_uir) uir_ir = o_ir_in;
            if (o_sdr) sdr_cyc++;
            if (o_sdr && p_sdr && o_tck !== p_tck) toggles++;
            if (o_udr) udr_w++;
            if (o_tck && !p_tck) begin
                if (o_udr) udr_rises++;
                if (o_sdr) begin
                    rx = {o_tdi, rx[DRW-1:1]};
                    sdr_rises++;
                    bidx++;
                    if (bidx < DRW) tdo = tdo_w[bidx];
                end
            end
            p_tck = o_tck; p_sdr = o_sdr;
            if (o_rsp_valid) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!o_rsp_valid) begin
            checks++; failures++;
            $display("FAIL scan_timeout rsp_valid=%b required=1", o_rsp_valid);
        end
        resp = o_rsp_dr; resp_ir = o_rsp_ir;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (o_rsp_dr !== resp || o_cmd_ready !== 1'b0 || o_rsp_valid !== 1'b1) hold_bad++;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        post_ready = o_cmd_ready; post_valid = o_rsp_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1; sel = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; tdo = 1'b0;
        ir_out = '0; cmd_ir = '0; cmd_dr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_all !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", o_all);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b required=1", o_cmd_ready);
        end
    endtask

    task automatic test_reset_mid_scan();
        int w, bad, rv;
        ir_out = 2'b11; cmd_ir = IR_TRACECTRL; cmd_dr = 38'h3F_FFFF_FFFF; sel = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while (!o_sdr && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (o_sdr !== 1'b1) begin
            failures++;
            $display("FAIL midscan_reach_sdr got=%b required=1", o_sdr);
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (o_all !== '0) begin
            failures++;
            $display("FAIL midscan_reset_outputs got=%h required=0", o_all);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_all !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midscan_reset_hold bad_cycles=%0d required=0", bad);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL midscan_release_ready got=%b required=1", o_cmd_ready);
        end
        rv = 0;
        repeat (400) begin
            @(negedge clk);
            if (o_rsp_valid) rv++;
        end
        checks++;
        if (rv != 0) begin
            failures++;
            $display("FAIL midscan_dropped_rsp rsp_valid_cycles=%0d required=0", rv);
        end
        ir_out = '0;
    endtask

    task automatic test_single_scan();
        sel = 1'b0; ir_out = '0;
        run_scan(IR_OCIMEM, 38'h2A_5555_5555, 38'h15_AAAA_AAAA, 0);
        checks++;
        if (resp !== 38'h15_AAAA_AAAA) begin
            failures++;
            $display("FAIL single_rsp_dr got=%h required=15aaaaaaaa", resp);
        end
        checks++;
        if (rx !== 38'h2A_5555_5555) begin
            failures++;
            $display("FAIL single_tdi_word got=%h required=2a55555555", rx);
        end
        checks++;
        if (uir_ir !== 2'd0) begin
            failures++;
            $display("FAIL single_ir_in got=%0d required=0", uir_ir);
        end
        checks++;
        if (sdr_rises != 38) begin
            failures++;
            $display("FAIL single_sdr_periods got=%0d required=38", sdr_rises);
        end
        checks++;
        if (lat != 344) begin
            failures++;
            $display("FAIL single_latency got=%0d required=344", lat);
        end
        checks++;
        if (udr_w != 8 || udr_rises != 1) begin
            failures++;
            $display("FAIL single_udr_pulse width=%0d rises=%0d required=8/1", udr_w, udr_rises);
        end
    endtask

    task automatic test_back_pressure();
        sel = 1'b0;
        run_scan(IR_TRACEMEM, 38'h00_0000_1234, 38'h3F_0F0F_0F0F, 10);
        checks++;
        if (hold_bad != 0) begin
            failures++;
            $display("FAIL bp_hold_stable bad_cycles=%0d required=0", hold_bad);
        end
        checks++;
        if (resp !== 38'h3F_0F0F_0F0F) begin
            failures++;
            $display("FAIL bp_rsp_dr got=%h required=3f0f0f0f0f", resp);
        end
        checks++;
        if (post_ready !== 1'b1 || post_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_after_handshake ready=%b valid=%b required=1/0", post_ready, post_valid);
        end
    endtask

    task automatic test_back_to_back();
        int   accepts, idle_gap, udr_pulses, hs;
        logic p_uir, p_udr;
        logic [IRW-1:0] ir_a, ir_b;
        accepts = 0; idle_gap = 0; udr_pulses = 0; hs = 0;
        p_uir = 1'b0; p_udr = 1'b0; ir_a = '0; ir_b = '0;
        sel = 1'b0;
        @(negedge clk);
        cmd_ir = IR_BREAK; cmd_dr = 38'h01_0000_0001; cmd_valid = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < 2000 && hs < 2; c++) begin
            if (o_uir && !p_uir) begin
                if (accepts == 1) ir_a = o_ir_in;
                else              ir_b = o_ir_in;
            end
            if (o_udr && !p_udr) udr_pulses++;
            if (o_rsp_valid) hs++;
            if (o_cmd_ready) begin
                if (accepts >= 1) idle_gap++;
                accepts++;
            end
            if (accepts == 1 && !o_cmd_ready) cmd_ir = IR_TRACECTRL;
            if (accepts == 2 && !o_cmd_ready) cmd_valid = 1'b0;
            p_uir = o_uir; p_udr = o_udr;
            @(negedge clk);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        checks++;
        if (ir_a !== 2'd2 || ir_b !== 2'd3) begin
            failures++;
            $display("FAIL b2b_ir_in first=%0d second=%0d required=2/3", ir_a, ir_b);
        end
        checks++;
        if (udr_pulses != 2) begin
            failures++;
            $display("FAIL b2b_udr_pulses got=%0d required=2", udr_pulses);
        end
        checks++;
        if (idle_gap != 1) begin
            failures++;
            $display("FAIL b2b_idle_gap got=%0d required=1", idle_gap);
        end
        checks++;
        if (hs != 2) begin
            failures++;
            $display("FAIL b2b_responses got=%0d required=2", hs);
        end
    endtask

    task automatic test_divider();
        sel = 1'b1;
        run_scan(IR_TRACECTRL, 38'h01_2345_6789, 38'h3E_DCBA_9876, 0);
        checks++;
        if (lat != 84) begin
            failures++;
            $display("FAIL div_latency got=%0d required=84", lat);
        end
        checks++;
        if (sdr_cyc != 76 || toggles != 75) begin
            failures++;
            $display("FAIL div_sdr_toggle sdr_cycles=%0d toggles=%0d required=76/75", sdr_cyc, toggles);
        end
        checks++;
        if (resp !== 38'h3E_DCBA_9876) begin
            failures++;
            $display("FAIL div_rsp_dr got=%h required=3edcba9876", resp);
        end
        checks++;
        if (rx !== 38'h01_2345_6789) begin
            failures++;
            $display("FAIL div_tdi_word got=%h required=0123456789", rx);
        end
        sel = 1'b0;
    endtask

    task automatic test_ir_readback();
        sel = 1'b0; ir_out = 2'b10;
        run_scan(IR_BREAK, 38'h00_0000_00FF, 38'h00_0000_0001, 0);
        checks++;
        if (resp_ir !== 2'b10) begin
            failures++;
            $display("FAIL ir_readback got=%b required=10", resp_ir);
        end
        checks++;
        if (uir_ir !== 2'd2) begin
            failures++;
            $display("FAIL ir_readback_ir_in got=%0d required=2", uir_ir);
        end
        ir_out = '0;
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_back_pressure();
        test_back_to_back();
        test_divider();
        test_ir_readback();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
